// File: rtl/bsg_comm_link_traffic_checker.sv
// bsg_comm_link_traffic_checker
// Loopback traffic generator/checker for one comm link. Each of nodes_p nodes
// sends iterations_p patterned packets, consumes and checks the returned packets
// on the low check_bytes_p lanes, keeps a sticky error flag and a saturating
// error count, and reports per-node and aggregate completion.
//
// Ports:
//   clk_i, async_reset_n_i        clock, asynchronous active-low reset
//   start_i                       pulse; starts every node that is in IDLE
//   valid_o/data_o/ready_i        per-node tx packet stream (node n in slice n)
//   valid_i/data_i/yumi_o         per-node rx packet stream
//   done_o, all_done_o            per-node and aggregate completion
//   error_o, err_count_o          sticky error flag, saturating error count
//   done_cycle_o                  cycle count captured when all_done_o first rises
//
// Optional feature: define BSG_TRAFFIC_CHECKER_WATCHDOG_EN to add a per-node
// rx-inactivity watchdog that forces a stalled node to DONE with an error.
module bsg_comm_link_traffic_checker #(
    parameter int unsigned nodes_p         = 1,
    parameter int unsigned channel_width_p = 8,
    parameter int unsigned ring_bytes_p    = 10,
    parameter int unsigned check_bytes_p   = 8,
    parameter int unsigned iterations_p    = 16,
    parameter int unsigned err_width_p     = 16,
    parameter int unsigned timeout_p       = 1024
) (
    input  logic                                            clk_i,
    input  logic                                            async_reset_n_i,
    input  logic                                            start_i,
    output logic [nodes_p-1:0]                              valid_o,
    output logic [nodes_p*ring_bytes_p*channel_width_p-1:0] data_o,
    input  logic [nodes_p-1:0]                              ready_i,
    input  logic [nodes_p-1:0]                              valid_i,
    input  logic [nodes_p*ring_bytes_p*channel_width_p-1:0] data_i,
    output logic [nodes_p-1:0]                              yumi_o,
    output logic [nodes_p-1:0]                              done_o,
    output logic                                            all_done_o,
    output logic [nodes_p-1:0]                              error_o,
    output logic [nodes_p*err_width_p-1:0]                  err_count_o,
    output logic [31:0]                                     done_cycle_o
);

    localparam int unsigned pkt_width_lp = ring_bytes_p * channel_width_p;
    localparam int unsigned chk_width_lp = check_bytes_p * channel_width_p;
    localparam int unsigned cnt_width_lp = $clog2(iterations_p + 1);
    localparam logic [err_width_p-1:0]  err_max_lp  = '1;
    // Only the low check_bytes_p lanes take part in the receive compare.
    localparam logic [pkt_width_lp-1:0] chk_mask_lp = pkt_width_lp'({chk_width_lp{1'b1}});
    localparam logic [cnt_width_lp-1:0] iter_lp     = cnt_width_lp'(iterations_p);

    if (check_bytes_p < 1 || check_bytes_p > ring_bytes_p || timeout_p < 1) begin : g_bad_params
        $error("bsg_comm_link_traffic_checker: invalid check_bytes_p or timeout_p");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Lane b of packet k for node n: (k*ring_bytes_p + b) XOR n, truncated to a lane.
    function automatic logic [pkt_width_lp-1:0] pattern(input int unsigned node,
                                                         input int unsigned k);
        logic [pkt_width_lp-1:0] p;
        p = '0;
        for (int unsigned b = 0; b < ring_bytes_p; b++) begin
            p[b*channel_width_p +: channel_width_p] =
                channel_width_p'(k * ring_bytes_p + b) ^ channel_width_p'(node);
        end
        return p;
    endfunction

    for (genvar n = 0; n < nodes_p; n++) begin : g_node
        state_e                  state_q, state_d;
        logic [cnt_width_lp-1:0] tx_cnt_q, tx_cnt_d;
        logic [cnt_width_lp-1:0] rx_cnt_q, rx_cnt_d;
        logic                    error_q, error_d;
        logic [err_width_p-1:0]  err_q, err_d;
        logic                    active, tx_fire, rx_fire, mismatch, err_inc;
        logic [pkt_width_lp-1:0] exp_pkt;
`ifdef BSG_TRAFFIC_CHECKER_WATCHDOG_EN
        localparam int unsigned wd_width_lp = $clog2(timeout_p + 1);
        logic [wd_width_lp-1:0] wd_q, wd_d;
        logic                   wd_expire;
`endif

        assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        assign valid_o[n] = (state_q == ST_RUN) && (tx_cnt_q < iter_lp);
        assign data_o[n*pkt_width_lp +: pkt_width_lp] = pattern(n, 32'(tx_cnt_q));
        assign yumi_o[n]  = valid_i[n] && (state_q != ST_IDLE);
        assign tx_fire    = valid_o[n] && ready_i[n];
        assign rx_fire    = yumi_o[n];
        assign exp_pkt    = pattern(n, 32'(rx_cnt_q));
        assign mismatch   = |((data_i[n*pkt_width_lp +: pkt_width_lp] ^ exp_pkt) & chk_mask_lp);

        // Next-state, counters and error bookkeeping.
        always_comb begin
            state_d  = state_q;
            tx_cnt_d = tx_cnt_q;
            rx_cnt_d = rx_cnt_q;
            error_d  = error_q;
            err_d    = err_q;
            err_inc  = 1'b0;

            if (tx_fire) begin
                tx_cnt_d = tx_cnt_q + cnt_width_lp'(1);
            end
            if (rx_fire && active && (rx_cnt_q < iter_lp)) begin
                rx_cnt_d = rx_cnt_q + cnt_width_lp'(1);
                err_inc  = mismatch;
            end
            // Anything arriving after completion is unexpected traffic.
            if (rx_fire && (state_q == ST_DONE)) begin
                err_inc = 1'b1;
            end

            // Transitions use the post-update counts so the final packet ends RUN.
            unique case (state_q)
                ST_IDLE:  if (start_i) state_d = ST_RUN;
                ST_RUN: begin
                    if ((tx_cnt_d == iter_lp) && (rx_cnt_d == iter_lp)) state_d = ST_DONE;
                    else if (tx_cnt_d == iter_lp)                         state_d = ST_DRAIN;
                end
                ST_DRAIN: if (rx_cnt_d == iter_lp) state_d = ST_DONE;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase

`ifdef BSG_TRAFFIC_CHECKER_WATCHDOG_EN
            wd_d      = (active && !rx_fire) ? wd_q + wd_width_lp'(1) : '0;
            wd_expire = active && !rx_fire && (wd_q == wd_width_lp'(timeout_p - 1));
            if (wd_expire) begin
                state_d = ST_DONE;
                err_inc = 1'b1;
            end
`endif

            if (err_inc) begin
                error_d = 1'b1;
                if (err_q != err_max_lp) err_d = err_q + err_width_p'(1);
            end
        end

        // Node state register.
        always_ff @(posedge clk_i or negedge async_reset_n_i) begin
            if (!async_reset_n_i) begin
                state_q  <= ST_IDLE;
                tx_cnt_q <= '0;
                rx_cnt_q <= '0;
                error_q  <= 1'b0;
                err_q    <= '0;
`ifdef BSG_TRAFFIC_CHECKER_WATCHDOG_EN
                wd_q     <= '0;
`endif
            end else begin
                state_q  <= state_d;
                tx_cnt_q <= tx_cnt_d;
                rx_cnt_q <= rx_cnt_d;
                error_q  <= error_d;
                err_q    <= err_d;
`ifdef BSG_TRAFFIC_CHECKER_WATCHDOG_EN
                wd_q     <= wd_d;
`endif
            end
        end

        assign done_o[n]  = (state_q == ST_DONE);
        assign error_o[n] = error_q;
        assign err_count_o[n*err_width_p +: err_width_p] = err_q;
    end

    assign all_done_o = &done_o;

    logic [31:0] cycle_q;
    logic [31:0] done_cycle_q;
    logic        done_seen_q;

    // Free-running cycle counter; stamp captured once on the first all-done.
    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            cycle_q      <= '0;
            done_cycle_q <= '0;
            done_seen_q  <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (all_done_o && !done_seen_q) begin
                done_seen_q  <= 1'b1;
                done_cycle_q <= cycle_q;
            end
        end
    end

    assign done_cycle_o = done_cycle_q;

endmodule

// File: tb/tb_bsg_comm_link_traffic_checker.sv
// Bench for bsg_comm_link_traffic_checker: two nodes, 16 packets each. Expected
// tx packets are queued per node before start and popped as the DUT emits them;
// the link is either a direct loopback (optionally corrupting one packet) or a
// delayed queue with random ready.
module tb_bsg_comm_link_traffic_checker;

    localparam int unsigned NODES = 2;
    localparam int unsigned CW    = 8;
    localparam int unsigned RB    = 10;
    localparam int unsigned CB    = 8;
    localparam int unsigned ITER  = 16;
    localparam int unsigned EW    = 16;
    localparam int unsigned TO    = 64;
    localparam int unsigned PW    = RB * CW;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [NODES-1:0]      valid_o, ready, valid_in, yumi, done, error;
    logic                  all_done;
    logic [NODES*PW-1:0]   data_o, data_in;
    logic [NODES*EW-1:0]   err_count;
    logic [31:0]           done_cycle;

    logic [NODES-1:0]      link_valid;
    logic [NODES*PW-1:0]   link_data;
    bit                    direct, rand_ready, corrupt_en, drop;
    int unsigned           corrupt_node, corrupt_pkt, delay, cyc;
    logic [PW-1:0]         corrupt_mask;
    logic [NODES-1:0]      last_yumi;
    int                    tx_seen [NODES];
    int                    rx_seen [NODES];
    logic [PW-1:0]         exp_q   [NODES][$];
    logic [PW-1:0]         lq_data [NODES][$];
    int unsigned           lq_time [NODES][$];
    int                    total = 0;
    int                    bad   = 0;

    always #5 clk = ~clk;

    bsg_comm_link_traffic_checker #(
        .nodes_p(NODES), .channel_width_p(CW), .ring_bytes_p(RB), .check_bytes_p(CB),
        .iterations_p(ITER), .err_width_p(EW), .timeout_p(TO)
    ) dut (
        .clk_i(clk), .async_reset_n_i(rst_n), .start_i(start),
        .valid_o(valid_o), .data_o(data_o), .ready_i(ready),
        .valid_i(valid_in), .data_i(data_in), .yumi_o(yumi),
        .done_o(done), .all_done_o(all_done), .error_o(error),
        .err_count_o(err_count), .done_cycle_o(done_cycle)
    );

    function automatic logic [PW-1:0] pattern(input int unsigned n, input int unsigned k);
        logic [PW-1:0] p;
        for (int b = 0; b < RB; b++) p[b*CW +: CW] = CW'((k * RB + b) % 256) ^ CW'(n % 256);
        return p;
    endfunction

    assign valid_in = direct ? valid_o : link_valid;

    always_comb begin
        data_in = direct ? data_o : link_data;
        if (direct && corrupt_en &&
            data_o[corrupt_node*PW +: PW] == pattern(corrupt_node, corrupt_pkt))
            data_in[corrupt_node*PW +: PW] = data_o[corrupt_node*PW +: PW] ^ corrupt_mask;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe at negedge, advance, then drive link/ready after the edge.
    task automatic tick();
        @(negedge clk);
        last_yumi = yumi;
        for (int n = 0; n < NODES; n++) begin
            if (valid_o[n] && ready[n]) begin
                if (exp_q[n].size() == 0) check($sformatf("tx_extra_n%0d", n), 1, 0);
                else check($sformatf("tx_data_n%0d", n), data_o[n*PW +: PW], exp_q[n].pop_front());
                if (!direct && !(drop && tx_seen[n] >= 3)) begin
                    lq_data[n].push_back(data_o[n*PW +: PW]);
                    lq_time[n].push_back(cyc + delay);
                end
                tx_seen[n]++;
            end
            if (yumi[n]) begin
                rx_seen[n]++;
                if (!direct && lq_data[n].size() > 0) begin
                    void'(lq_data[n].pop_front());
                    void'(lq_time[n].pop_front());
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int n = 0; n < NODES; n++) begin
            ready[n] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (lq_data[n].size() > 0 && lq_time[n][0] <= cyc) begin
                link_valid[n] = 1'b1;
                link_data[n*PW +: PW] = lq_data[n][0];
            end else begin
                link_valid[n] = 1'b0;
                link_data[n*PW +: PW] = '0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; direct = 1'b0; rand_ready = 1'b0; corrupt_en = 1'b0;
        drop = 1'b0; delay = 1;
        for (int n = 0; n < NODES; n++) begin
            exp_q[n].delete(); lq_data[n].delete(); lq_time[n].delete();
            tx_seen[n] = 0; rx_seen[n] = 0;
        end
        repeat (2) tick();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic load_expected();
        for (int n = 0; n < NODES; n++)
            for (int k = 0; k < ITER; k++) exp_q[n].push_back(pattern(n, k));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n_cyc);
        n_cyc = 0;
        while (all_done !== 1'b1 && n_cyc < budget) begin
            tick();
            n_cyc++;
        end
        check("done_reached", all_done, 1);
    endtask

    int          lat;
    int unsigned stamp;

    initial begin
        rst_n = 1'b0; start = 1'b0; ready = '1; link_valid = '0; link_data = '0;
        direct = 1'b0; corrupt_en = 1'b0; corrupt_mask = '0; corrupt_node = 0;
        corrupt_pkt = 0; cyc = 0; last_yumi = '0;
        do_reset();
        rst_n = 1'b0;
        link_valid = '1;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_yumi", yumi, 0);
        check("rst_done", {all_done, done}, 0);
        check("rst_error", error, 0);
        check("rst_err_count", err_count, 0);
        check("rst_done_cycle", done_cycle, 0);
        rst_n = 1'b1;
        cyc = 0;
        #2;
        check("idle_yumi", yumi, 0);
        tick();
        check("idle_no_valid", valid_o, 0);

        // Direct loopback, clean.
        do_reset();
        direct = 1'b1;
        load_expected();
        pulse_start();
        wait_done(100, lat);
        check("t1_latency", lat, ITER);
        check("t1_error", error, 0);
        check("t1_err_count", err_count, 0);
        check("t1_tx_n0", tx_seen[0], ITER);
        check("t1_tx_n1", tx_seen[1], ITER);
        check("t1_rx_n1", rx_seen[1], ITER);
        check("t1_exp_left", exp_q[0].size() + exp_q[1].size(), 0);
        stamp = cyc;
        check("t1_stamp_lag", done_cycle, 0);
        tick();
        check("t1_done_cycle", done_cycle, stamp);
        repeat (2) tick();
        check("t1_stamp_hold", done_cycle, stamp);

        // Corrupt checked lane 0 of node 1 packet 5.
        do_reset();
        direct = 1'b1; corrupt_en = 1'b1; corrupt_node = 1; corrupt_pkt = 5;
        corrupt_mask = '0; corrupt_mask[0 +: CW] = 8'h5A;
        load_expected();
        pulse_start();
        wait_done(100, lat);
        check("t2_error", error, 2'b10);
        check("t2_err_n1", err_count[EW +: EW], 1);
        check("t2_err_n0", err_count[0 +: EW], 0);
        check("t2_done", done, 2'b11);

        // Corrupt unchecked lane check_bytes_p.
        do_reset();
        direct = 1'b1; corrupt_en = 1'b1; corrupt_node = 1; corrupt_pkt = 5;
        corrupt_mask = '0; corrupt_mask[CB*CW +: CW] = 8'h5A;
        load_expected();
        pulse_start();
        wait_done(100, lat);
        check("t3_error", error, 0);
        check("t3_err_count", err_count, 0);

        // Random ready, 3-cycle link delay.
        do_reset();
        rand_ready = 1'b1; delay = 3;
        load_expected();
        pulse_start();
        wait_done(600, lat);
        check("t4_tx_n0", tx_seen[0], ITER);
        check("t4_tx_n1", tx_seen[1], ITER);
        check("t4_rx_n0", rx_seen[0], ITER);
        check("t4_rx_n1", rx_seen[1], ITER);
        check("t4_error", error, 0);
        check("t4_exp_left", exp_q[0].size() + exp_q[1].size(), 0);

        // Two unexpected packets on node 0 after DONE; start is ignored.
        lq_data[0].push_back(pattern(0, 0)); lq_time[0].push_back(cyc);
        lq_data[0].push_back(pattern(0, 1)); lq_time[0].push_back(cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t5_yumi_a", last_yumi[0], 1);
        tick();
        check("t5_yumi_b", last_yumi[0], 1);
        tick();
        check("t5_yumi_idle", last_yumi[0], 0);
        check("t5_err_n0", err_count[0 +: EW], 2);
        check("t5_err_n1", err_count[EW +: EW], 0);
        check("t5_error", error, 2'b01);
        check("t5_no_restart", valid_o, 0);

        // Reset mid-RUN after an error has been counted.
        do_reset();
        direct = 1'b1; corrupt_en = 1'b1; corrupt_node = 1; corrupt_pkt = 2;
        corrupt_mask = '0; corrupt_mask[0 +: CW] = 8'h01;
        load_expected();
        pulse_start();
        repeat (5) tick();
        check("t6_pre_valid", valid_o, 2'b11);
        check("t6_pre_err", err_count[EW +: EW], 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", valid_o, 0);
        check("t6_yumi", yumi, 0);
        check("t6_done", {all_done, done}, 0);
        check("t6_error", error, 0);
        check("t6_err_count", err_count, 0);
        check("t6_done_cycle", done_cycle, 0);

`ifdef BSG_TRAFFIC_CHECKER_WATCHDOG_EN
        // Link stalls after packet 3; the watchdog must end both nodes with one error.
        do_reset();
        drop = 1'b1;
        load_expected();
        pulse_start();
        wait_done(300, lat);
        check("wd_rx_n0", rx_seen[0], 3);
        check("wd_error", error, 2'b11);
        check("wd_err_n0", err_count[0 +: EW], 1);
        check("wd_err_n1", err_count[EW +: EW], 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsg_comm_link_traffic_checker.md
# bsg_comm_link_traffic_checker

Synthesizable, parametrised traffic generator and checker for comm-link loopback testing, instantiated at the gateway core side of `bsg_guts` with one instance per link. It drives `nodes_p` independent packet streams into the link's core-node ports, checks the returned packets against the expected pattern, counts errors and asserts per-node and aggregate completion. It generalises the simulation-only link checker:

- configurable node count, lane width and packet length;
- sticky error reporting;
- a completion cycle stamp;
- an optional watchdog.

## Interface
Parameters:
- nodes_p, 1, number of independent streams
- channel_width_p, 8, bits per lane
- ring_bytes_p, 10, lanes per packet; packet width = ring_bytes_p*channel_width_p
- check_bytes_p, 8, low lanes compared on receive (1..ring_bytes_p)
- iterations_p, 16, packets sent and expected per node
- err_width_p, 16, error counter width (saturating)
- timeout_p, 1024, watchdog limit in cycles (used only with the watchdog macro)

Ports:
- clk_i  in  1  sole clock
- async_reset_n_i  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle pulse; starts all nodes in IDLE
- valid_o  out  nodes_p  tx packet valid per node
- data_o  out  nodes_p*packet width  tx packet; node n occupies slice n
- ready_i  in  nodes_p  link accepts tx packet
- valid_i  in  nodes_p  rx packet valid
- data_i  in  nodes_p*packet width  rx packet
- yumi_o  out  nodes_p  rx packet consumed this cycle
- done_o  out  nodes_p  node reached DONE
- all_done_o  out  1  AND of done_o
- error_o  out  nodes_p  sticky mismatch or unexpected-packet flag
- err_count_o  out  nodes_p*err_width_p  per-node error count
- done_cycle_o  out  32  free-running cycle count latched when all_done_o first rises

## Operation
- Per-node FSM with four states:
  - IDLE -> RUN on start_i.
  - RUN -> DRAIN when tx_cnt == iterations_p.
  - DRAIN -> DONE when rx_cnt == iterations_p.
  - DONE is terminal until reset.
- RUN -> DONE directly if both counts complete in the same cycle.
- Tx pattern for packet k of node n: lane b = (k*ring_bytes_p + b) mod 2^channel_width_p, XOR (n mod 2^channel_width_p).
- valid_o[n] = (state==RUN) & (tx_cnt < iterations_p). tx_cnt increments on valid_o & ready_i.
- yumi_o[n] = valid_i[n] & state ∈ {RUN, DRAIN, DONE}. In IDLE, yumi_o is 0 and the packet is left on the link.
- In RUN/DRAIN, when rx_cnt < iterations_p, each consumed packet is compared against the expected pattern for k = rx_cnt, on lanes 0..check_bytes_p-1 only.
  - Mismatch: error_o set, err_count +1.
  - rx_cnt increments regardless of match.
- In DONE, every consumed packet counts as an unexpected-packet error.
- err_count saturates at 2^err_width_p-1.
- Cycle counter runs from reset. done_cycle_o latches once on the first rising edge of all_done_o and holds until reset.

## Timing
- Reset values:
  - All FSMs in IDLE.
  - valid_o, yumi_o, done_o, all_done_o, error_o = 0.
  - err_count_o, done_cycle_o, counters = 0.
- Reset is asynchronous on assertion and is used synchronously-released. It aborts any in-flight operation immediately; no packet is counted in the reset cycle.
- valid_o, data_o and done_o are registered-state functions: data_o is combinational from tx_cnt with no added latency. The first valid_o occurs the cycle after start_i.
- yumi_o is combinational from valid_i and state. Compare and count update on the same edge.
- Simultaneous tx accept and rx consume in one cycle are both counted.
- start_i outside IDLE is ignored.
- all_done_o is combinational from done_o. done_cycle_o updates one cycle after all_done_o rises.

## Configuration
- BSG_TRAFFIC_CHECKER_WATCHDOG_EN defined: per-node counter of cycles in RUN/DRAIN since the last rx consume (cleared on consume).
  - On reaching timeout_p, the node goes to DONE with error_o set and err_count +1.
- Macro undefined: no watchdog logic; timeout_p is ignored, and a stalled link leaves the node in RUN/DRAIN indefinitely.

## Test plan
- Loopback data_o->data_i, ready_i=1, nodes_p=2, iterations_p=16 -> both nodes DONE after 17 cycles from start_i; error_o=0; done_cycle_o captured.
- Corrupt lane 0 of rx packet 5 on node 1 -> error_o=2'b10, err_count[1]=1, done still asserted.
- Corrupt lane check_bytes_p (unchecked lane) -> no error.
- ready_i toggling 50% with 3-cycle rx delay -> exactly 16 packets sent and received per node, pattern contiguous, no error.
- Inject two extra rx packets after DONE -> err_count=2, yumi_o=1 both cycles.
- Watchdog build, timeout_p=64, rx stalled after packet 3 -> DONE with err_count=1 after 64 idle cycles.
- Assert reset mid-RUN -> all outputs return to reset values the same cycle.
